// File: rtl/wfg_core_pkg.sv
// Shared types and default widths for the wfg_core burst sequencer.
package wfg_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_GAP
  } burst_state_e;

  localparam int unsigned LEN_W_DEF = 16;
  localparam int unsigned GAP_W_DEF = 16;
  localparam int unsigned REP_W_DEF = 8;

endpackage

// File: rtl/wfg_core_burst_ctrl.sv
// Burst sequencer in front of wfg_core: gates the core enable so the pattern
// runs for a programmed number of sync periods, repeated with an idle gap.
module wfg_core_burst_ctrl
  import wfg_core_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_en_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [LEN_W-1:0] cfg_burst_len_i,
  input  logic [REP_W-1:0] cfg_repeat_i,
  input  logic [GAP_W-1:0] cfg_gap_i,
  input  logic             wfg_pat_sync_i,
  input  logic             core_active_i,
  output logic             core_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [REP_W-1:0] burst_cnt_o
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  burst_state_e     state;
  logic             sync_q;
  logic             sync_rise;
  logic             abort_q;
  logic             last_sync;
  logic             reps_done;
  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [LEN_W-1:0] sync_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // Sync edge detection and burst-completion conditions
  always_comb begin
    sync_rise = wfg_pat_sync_i & ~sync_q;
    last_sync = sync_rise && (len_q != '0) && (sync_cnt == len_q - LEN_ONE);
    reps_done = (rep_q != '0) && (burst_cnt_o == rep_q);
  end

  // Sync level history, sampled every cycle regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= wfg_pat_sync_i;
    end
  end

  // Sequencer state, shadow configuration, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      core_en_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      burst_cnt_o <= '0;
      abort_q     <= 1'b0;
      len_q       <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      sync_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      done_o <= 1'b0;
      if (!ctrl_en_i) begin
        state     <= ST_IDLE;
        core_en_o <= 1'b0;
        busy_o    <= 1'b0;
        abort_q   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i && !stop_i) begin
              state       <= ST_RUN;
              len_q       <= cfg_burst_len_i;
              rep_q       <= cfg_repeat_i;
              gap_q       <= cfg_gap_i;
              burst_cnt_o <= '0;
              sync_cnt    <= '0;
              abort_q     <= 1'b0;
              core_en_o   <= 1'b1;
              busy_o      <= 1'b1;
            end
          end
          ST_RUN: begin
            // Completion takes priority so a simultaneous stop still counts the burst
            if (last_sync) begin
              state       <= ST_DRAIN;
              core_en_o   <= 1'b0;
              burst_cnt_o <= (burst_cnt_o == '1) ? burst_cnt_o : burst_cnt_o + 1'b1;
              if (stop_i) abort_q <= 1'b1;
            end else if (stop_i) begin
              state     <= ST_DRAIN;
              core_en_o <= 1'b0;
              abort_q   <= 1'b1;
            end else if (sync_rise) begin
              sync_cnt <= sync_cnt + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (stop_i) abort_q <= 1'b1;
            if (!core_active_i) begin
              if (abort_q || stop_i || reps_done) begin
                state   <= ST_IDLE;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
                abort_q <= 1'b0;
              end else if (gap_q == '0) begin
                state     <= ST_RUN;
                sync_cnt  <= '0;
                core_en_o <= 1'b1;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= gap_q - 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (stop_i) begin
              state   <= ST_DRAIN;
              abort_q <= 1'b1;
            end else if (gap_cnt == '0) begin
              state     <= ST_RUN;
              sync_cnt  <= '0;
              core_en_o <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wfg_core_burst_ctrl.sv
// Self-checking bench for wfg_core_burst_ctrl: a behavioural burst model is
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_wfg_core_burst_ctrl;

  localparam int LW = 16;
  localparam int GW = 16;
  localparam int RW = 8;
  localparam int BCNT_MAX = (1 << RW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_GAP   = 3;

  logic          clk;
  logic          rst_n;
  logic          ctrl_en_i;
  logic          start_i;
  logic          stop_i;
  logic [LW-1:0] cfg_burst_len_i;
  logic [RW-1:0] cfg_repeat_i;
  logic [GW-1:0] cfg_gap_i;
  logic          wfg_pat_sync_i;
  logic          core_active_i;
  logic          core_en_o;
  logic          busy_o;
  logic          done_o;
  logic [RW-1:0] burst_cnt_o;

  wfg_core_burst_ctrl #(.LEN_W(LW), .GAP_W(GW), .REP_W(RW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_en_i       (ctrl_en_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .cfg_burst_len_i (cfg_burst_len_i),
    .cfg_repeat_i    (cfg_repeat_i),
    .cfg_gap_i       (cfg_gap_i),
    .wfg_pat_sync_i  (wfg_pat_sync_i),
    .core_active_i   (core_active_i),
    .core_en_o       (core_en_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .burst_cnt_o     (burst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts remaining rises and gap cycles per burst
  typedef struct packed {
    int mode;
    int rises_left;
    int gap_left;
    int bcnt;
    int len;
    int rep;
    int gap;
    bit done;
    bit aborted;
    bit sync_prev;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t model_step(input mdl_t c);
    mdl_t n = c;
    bit rise;
    rise = wfg_pat_sync_i && !c.sync_prev;
    n.sync_prev = wfg_pat_sync_i;
    n.done = 1'b0;
    if (!ctrl_en_i) begin
      n.mode = M_IDLE;
      n.aborted = 1'b0;
    end else begin
      case (c.mode)
        M_IDLE: if (start_i && !stop_i) begin
          n.mode = M_RUN;
          n.len = int'(cfg_burst_len_i);
          n.rep = int'(cfg_repeat_i);
          n.gap = int'(cfg_gap_i);
          n.bcnt = 0;
          n.rises_left = n.len;
          n.aborted = 1'b0;
        end
        M_RUN: begin
          if (rise && c.len != 0 && c.rises_left == 1) begin
            n.bcnt = (c.bcnt == BCNT_MAX) ? c.bcnt : c.bcnt + 1;
            n.mode = M_DRAIN;
            if (stop_i) n.aborted = 1'b1;
          end else if (stop_i) begin
            n.aborted = 1'b1;
            n.mode = M_DRAIN;
          end else if (rise && c.len != 0) begin
            n.rises_left = c.rises_left - 1;
          end
        end
        M_DRAIN: begin
          if (stop_i) n.aborted = 1'b1;
          if (!core_active_i) begin
            if (n.aborted || (c.rep != 0 && c.bcnt == c.rep)) begin
              n.mode = M_IDLE;
              n.done = 1'b1;
              n.aborted = 1'b0;
            end else if (c.gap == 0) begin
              n.mode = M_RUN;
              n.rises_left = c.len;
            end else begin
              n.mode = M_GAP;
              n.gap_left = c.gap;
            end
          end
        end
        default: begin
          if (stop_i) begin
            n.aborted = 1'b1;
            n.mode = M_DRAIN;
          end else begin
            n.gap_left = c.gap_left - 1;
            if (n.gap_left == 0) begin
              n.mode = M_RUN;
              n.rises_left = c.len;
            end
          end
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= '0;
    else        mdl <= model_step(mdl);
  end

  // Per-cycle comparison and enable-run statistics
  int hi_q[$];
  int lo_q[$];
  int hi_len, lo_len, drain_cnt, done_cnt;
  bit seen_hi, mon_prev_en;

  initial begin
    hi_len = 0; lo_len = 0; drain_cnt = 0; done_cnt = 0;
    seen_hi = 1'b0; mon_prev_en = 1'b0;
  end

  always @(negedge clk) begin
    check("cyc_core_en", 32'(core_en_o), 32'(mdl.mode == M_RUN));
    check("cyc_busy", 32'(busy_o), 32'(mdl.mode != M_IDLE));
    check("cyc_done", 32'(done_o), 32'(mdl.done));
    check("cyc_burst_cnt", 32'(burst_cnt_o), mdl.bcnt);
    if (done_o === 1'b1) done_cnt++;
    if (busy_o === 1'b1 && core_en_o === 1'b0) drain_cnt++;
    if (core_en_o === 1'b1) begin
      if (!mon_prev_en && seen_hi) lo_q.push_back(lo_len);
      hi_len++;
      lo_len = 0;
    end else begin
      if (mon_prev_en) begin
        hi_q.push_back(hi_len);
        seen_hi = 1'b1;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      hi_len = 0;
    end
    mon_prev_en = (core_en_o === 1'b1);
  end

  // Stand-in for wfg_core: active follows enable one cycle late, one sync
  // pulse every third cycle while enabled, optional extended active hold
  int  phase = 0;
  int  rise_cnt = 0;
  int  hold_cnt = 0;
  bit  hold_req = 1'b0;
  bit  drv_prev_en = 1'b0;

  always @(negedge clk) begin
    if (hold_req && drv_prev_en && core_en_o === 1'b0) hold_cnt = 20;
    if (hold_cnt > 0) begin
      core_active_i = 1'b1;
      hold_cnt--;
    end else begin
      core_active_i = (core_en_o === 1'b1);
    end
    if (core_en_o === 1'b1) phase = (phase == 2) ? 0 : phase + 1;
    else                    phase = 0;
    wfg_pat_sync_i = (core_en_o === 1'b1) && (phase == 2);
    if (wfg_pat_sync_i) rise_cnt++;
    drv_prev_en = (core_en_o === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic kick(input int len, input int rep, input int gap);
    cfg_burst_len_i = LW'(len);
    cfg_repeat_i    = RW'(rep);
    cfg_gap_i       = GW'(gap);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (done_o === 1'b1) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 1);
  endtask

  task automatic clear_stats();
    hi_q.delete();
    lo_q.delete();
    seen_hi = 1'b0;
    rise_cnt = 0;
    drain_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int dbase;
    bit ok;
    rst_n = 1'b0; ctrl_en_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    cfg_burst_len_i = '0; cfg_repeat_i = '0; cfg_gap_i = '0;
    wfg_pat_sync_i = 1'b0; core_active_i = 1'b0;
    repeat (2) tick();
    check("rst_core_en", 32'(core_en_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_burst_cnt", 32'(burst_cnt_o), 0);
    rst_n = 1'b1;
    tick();

    // Three rises per burst, two bursts, four gap cycles
    clear_stats();
    dbase = done_cnt;
    kick(3, 2, 4);
    wait_done(200, "s1");
    tick();
    check("s1_burst_cnt", 32'(burst_cnt_o), 2);
    check("s1_busy_after", 32'(busy_o), 0);
    check("s1_done_pulses", done_cnt - dbase, 1);
    check("s1_bursts", hi_q.size(), 2);
    check("s1_hi0_len", (hi_q.size() > 0) ? hi_q[0] : -1, 8);
    check("s1_hi1_len", (hi_q.size() > 1) ? hi_q[1] : -1, 8);
    check("s1_gap_count", lo_q.size(), 1);
    check("s1_en_low_len", (lo_q.size() > 0) ? lo_q[0] : -1, 5);

    // Infinite repeats, abort in the second burst
    clear_stats();
    kick(5, 0, 0);
    for (int i = 0; i < 200 && rise_cnt < 7; i++) tick();
    check("s2_rises_reached", 32'(rise_cnt >= 7), 1);
    repeat (2) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("s2_en_drop", 32'(core_en_o), 0);
    wait_done(20, "s2");
    tick();
    check("s2_burst_cnt", 32'(burst_cnt_o), 1);
    check("s2_busy_after", 32'(busy_o), 0);

    // Continuous mode, then master enable removed
    clear_stats();
    kick(0, 0, 0);
    low = 0;
    for (int i = 0; i < 4000 && rise_cnt < 1000; i++) begin
      tick();
      if (core_en_o !== 1'b1) low++;
    end
    check("s3_rises", 32'(rise_cnt >= 1000), 1);
    check("s3_en_low_cycles", low, 0);
    dbase = done_cnt;
    ctrl_en_i = 1'b0;
    tick();
    check("s3_en_off", 32'(core_en_o), 0);
    check("s3_busy_off", 32'(busy_o), 0);
    ctrl_en_i = 1'b1;
    repeat (3) tick();
    check("s3_no_done", done_cnt - dbase, 0);
    check("s3_burst_cnt_hold", 32'(burst_cnt_o), 0);

    // Start and stop together stay idle; start during a run is ignored
    start_i = 1'b1; stop_i = 1'b1;
    cfg_burst_len_i = LW'(2); cfg_repeat_i = RW'(1); cfg_gap_i = '0;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    tick();
    check("s4_dual_busy", 32'(busy_o), 0);
    check("s4_dual_en", 32'(core_en_o), 0);
    clear_stats();
    kick(2, 1, 0);
    tick();
    cfg_burst_len_i = LW'(6);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(100, "s4");
    tick();
    check("s4_rises_in_burst", rise_cnt, 2);
    check("s4_burst_cnt", 32'(burst_cnt_o), 1);

    // Core stays active long after the final burst
    clear_stats();
    hold_req = 1'b1;
    kick(1, 1, 0);
    wait_done(100, "s5");
    hold_req = 1'b0;
    tick();
    check("s5_drain_cycles", drain_cnt, 21);

    // Asynchronous reset while waiting out the gap
    clear_stats();
    kick(2, 3, 10);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (burst_cnt_o == RW'(1) && core_en_o === 1'b0) ok = 1'b1;
    end
    check("s6_first_burst", 32'(ok), 1);
    repeat (3) tick();
    check("s6_gap_busy", 32'(busy_o), 1);
    check("s6_gap_en", 32'(core_en_o), 0);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_busy", 32'(busy_o), 0);
    check("s6_rst_en", 32'(core_en_o), 0);
    check("s6_rst_done", 32'(done_o), 0);
    check("s6_rst_burst_cnt", 32'(burst_cnt_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    kick(2, 1, 0);
    wait_done(100, "s6");
    tick();
    check("s6_fresh_burst_cnt", 32'(burst_cnt_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
